shift_seq_ctrl: RTL and testbench

Multi-cycle shift/rotate controller for the execute-stage shifter. It accepts one operand, shift count and op code per transaction. It sequences a single shared stage datapath through the power-of-two distances (8, 4, 2, 1), one stage per cycle, applying only the stages whose count bit is set. It returns the result with a one-cycle done pulse, so a long combinational barrel chain is replaced by a registered, lower-area iterative path.

---
 rtl/shift_seq_ctrl_if.sv | 19 +
 rtl/shift_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_shift_seq_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/shift_seq_ctrl_if.sv
// Request/result bundle for the iterative shift/rotate controller.
// master drives the request, slave is the shifter.
interface shift_seq_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] in;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;

  modport master (output start, output op, output in, output cnt,
                  input  busy,  input  done, input  out);
  modport slave  (input  start, input  op,  input  in,  input  cnt,
                  output busy,  output done, output out);
endinterface

// File: rtl/shift_seq_ctrl.sv
// Iterative shifter: one power-of-two stage per cycle (8,4,2,1), done pulse at the end.
// Define SHIFT_SEQ_SKIP_EN to skip stages whose count bit is clear.
module shift_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_seq_ctrl_if.slave       bus
);
  localparam int KW = (CNT_W > 1) ? $clog2(CNT_W) : 1;
  localparam logic [KW-1:0] K_TOP = KW'(CNT_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STG  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             busy_q, done_q;

  function automatic logic [WIDTH-1:0] shift_stage(input logic [WIDTH-1:0] a,
                                                   input logic [1:0]       o,
                                                   input logic [KW-1:0]    k);
    int unsigned d;
    logic [WIDTH-1:0] r;
    d = 32'd1 << k;
    case (o)
      2'b00:   r = (a << d) | (a >> (32'(WIDTH) - d));
      2'b01:   r = a << d;
      2'b10:   r = (a >> d) | (a << (32'(WIDTH) - d));
      2'b11:   r = a >> d;
      default: r = a;
    endcase
    return r;
  endfunction

`ifdef SHIFT_SEQ_SKIP_EN
  // Highest set bit of c strictly below lim; MSB of the result flags "found".
  function automatic logic [KW:0] next_set(input logic [CNT_W-1:0] c, input int lim);
    logic [KW:0] r;
    r = '0;
    for (int i = 0; i < CNT_W; i++) begin
      r = (i < lim && c[i]) ? {1'b1, KW'(i)} : r;
    end
    return r;
  endfunction

  logic [KW:0] idle_nxt_s, stg_nxt_s;
  assign idle_nxt_s = next_set(bus.cnt, CNT_W);
  assign stg_nxt_s  = next_set(cnt_q, int'(k_q));
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          acc_d = bus.in;
          op_d  = bus.op;
          cnt_d = bus.cnt;
`ifdef SHIFT_SEQ_SKIP_EN
          if (idle_nxt_s[KW]) begin
            state_d = ST_STG;
            k_d     = idle_nxt_s[KW-1:0];
          end else begin
            state_d = ST_DONE;
            out_d   = bus.in;
          end
`else
          state_d = ST_STG;
          k_d     = K_TOP;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STG: begin
        if (cnt_q[k_q]) begin
          acc_d = shift_stage(acc_q, op_q, k_q);
        end else begin
          acc_d = acc_q;
        end
`ifdef SHIFT_SEQ_SKIP_EN
        if (stg_nxt_s[KW]) begin
          k_d = stg_nxt_s[KW-1:0];
        end else begin
          state_d = ST_DONE;
          out_d   = acc_d;
        end
`else
        if (k_q == '0) begin
          state_d = ST_DONE;
          out_d   = acc_d;
        end else begin
          k_d = k_q - KW'(1'b1);
        end
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; busy/done registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      op_q    <= 2'b00;
      cnt_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.out  = out_q;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed + scoreboard bench for shift_seq_ctrl; latency expectations follow SHIFT_SEQ_SKIP_EN.
module tb_shift_seq_ctrl;
  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [WIDTH-1:0] exp_q[$];
  int               lat_q[$];
  logic [WIDTH-1:0] prev_out = '0;

  shift_seq_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
  shift_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] ref_shift(input logic [1:0] o,
                                                 input logic [WIDTH-1:0] a, input int c);
    case (o)
      2'b00:   return (a << c) | (a >> (WIDTH - c));
      2'b01:   return a << c;
      2'b10:   return (a >> c) | (a << (WIDTH - c));
      default: return a >> c;
    endcase
  endfunction

  function automatic int exp_lat(input logic [CNT_W-1:0] c);
`ifdef SHIFT_SEQ_SKIP_EN
    return $countones(c) + 1;
`else
    return CNT_W + 1;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one request; returns in the first cycle after the accepting edge.
  task automatic start_txn(input logic [1:0] o, input logic [WIDTH-1:0] a,
                           input logic [CNT_W-1:0] c, input logic [WIDTH-1:0] e);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.in = a; bus.cnt = c;
    exp_q.push_back(e);
    lat_q.push_back(exp_lat(c));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Wait (bounded) for done; optionally pulse a competing start at cycle pulse_at.
  task automatic wait_done(input int pulse_at);
    int n;
    int l;
    logic [WIDTH-1:0] e;
    n = 1;
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    while (bus.done !== 1'b1 && n < 40) begin
      check("busy_wait", 32'(bus.busy), 32'd1);
      check("out_hold", 32'(bus.out), 32'(prev_out));
      if (n == pulse_at) begin
        bus.start = 1'b1; bus.in = ~bus.in; bus.op = ~bus.op; bus.cnt = ~bus.cnt;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    check("done_seen", 32'(bus.done), 32'd1);
    check("latency", 32'(n), 32'(l));
    check("busy_done", 32'(bus.busy), 32'd1);
    check("result", 32'(bus.out), 32'(e));
    prev_out = e;
    @(negedge clk);
    check("done_pulse", 32'(bus.done), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("out_after", 32'(bus.out), 32'(prev_out));
  endtask

  initial begin
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_in;
    logic [CNT_W-1:0] r_cnt;

    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.in = '0; bus.cnt = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_out", 32'(bus.out), 32'd0);
    rst = 1'b0;

    start_txn(2'b01, 16'h0001, 4'd15, 16'h8000); wait_done(0);
    start_txn(2'b00, 16'h1234, 4'd4,  16'h2341); wait_done(0);
    start_txn(2'b10, 16'h0001, 4'd1,  16'h8000); wait_done(0);
    start_txn(2'b11, 16'h8000, 4'd8,  16'h0080); wait_done(0);
    start_txn(2'b11, 16'hFFFF, 4'd15, 16'h0001); wait_done(0);
    start_txn(2'b01, 16'hABCD, 4'd0,  16'hABCD); wait_done(0);
    start_txn(2'b01, 16'h0003, 4'd9,  16'h0600); wait_done(0);

    // Competing start (and changed op/cnt) while busy must be ignored.
    start_txn(2'b01, 16'h0001, 4'd15, 16'h8000); wait_done(2);
    start_txn(2'b10, 16'h00F0, 4'd4,  16'h000F); wait_done(0);

    for (int i = 0; i < 6; i++) begin
      r_op  = 2'($urandom_range(0, 3));
      r_in  = 16'($urandom);
      r_cnt = 4'($urandom_range(0, 15));
      start_txn(r_op, r_in, r_cnt, ref_shift(r_op, r_in, int'(r_cnt)));
      wait_done(0);
    end

    // Reset mid-transaction: accept at T, rst sampled at the edge ending T+3.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.in = 16'h1234; bus.cnt = 4'd15;
    @(negedge clk);
    bus.start = 1'b0;
    check("mid_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_out", 32'(bus.out), 32'd0);
    rst = 1'b0;
    prev_out = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_done_after_abort", 32'(bus.done), 32'd0);
    end

    // rst and start at the same edge: reset wins, nothing accepted.
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1; bus.op = 2'b01; bus.in = 16'h00FF; bus.cnt = 4'd1;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    check("rst_start_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("rst_start_idle", 32'(bus.busy), 32'd0);

    start_txn(2'b01, 16'h00FF, 4'd4, 16'h0FF0); wait_done(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
